clock_calendar_set: RTL and testbench

Parametrised successor of the decade clock/calendar: a BCD time-of-day plus full Gregorian date counter with button-driven set mode, blinking field indication and registered 7-segment outputs. Sits between the board switches/keys and the eight 7-segment displays. Adds what the first generation lacked: a configurable tick divider, a configurable reset year, correct days-per-month and century leap rules, and a field-select set FSM with increment/decrement.

---
 rtl/clock_calendar_set.sv | 247 ++++++++++++++++++++++++
 tb/tb_clock_calendar_set.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_calendar_set.sv
// BCD time-of-day and Gregorian calendar with a button-driven set FSM,
// a blinking selected field and registered active-low 7-segment outputs.
`timescale 1ns/1ps
module clock_calendar_set #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TICK_W     = 26,
  parameter int RESET_YEAR = 2024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw_mode,
  input  logic       butt_increase,
  input  logic       butt_decrease,
  input  logic       butt_change,
  output logic [6:0] seg7,
  output logic [6:0] seg6,
  output logic [6:0] seg5,
  output logic [6:0] seg4,
  output logic [6:0] seg3,
  output logic [6:0] seg2,
  output logic [6:0] seg1,
  output logic [6:0] seg0,
  output logic       tick_1s,
  output logic       setting
);

  localparam logic [2:0] ST_RUN   = 3'd0;
  localparam logic [2:0] ST_HOUR  = 3'd1;
  localparam logic [2:0] ST_MIN   = 3'd2;
  localparam logic [2:0] ST_SEC   = 3'd3;
  localparam logic [2:0] ST_DAY   = 3'd4;
  localparam logic [2:0] ST_MONTH = 3'd5;
  localparam logic [2:0] ST_YEAR  = 3'd6;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_DIV / 2);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [15:0] RESET_YEAR_BCD = {4'((RESET_YEAR / 1000) % 10), 4'((RESET_YEAR / 100) % 10),
                                            4'((RESET_YEAR / 10) % 10), 4'(RESET_YEAR % 10)};
  localparam logic [6:0] BLANK = 7'h7F;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [15:0] year_inc(input logic [15:0] y);
    if (y == 16'h9999)       return 16'h0000;
    else if (y[7:0] == 8'h99) return {bcd_inc(y[15:8]), 8'h00};
    else                      return {y[15:8], bcd_inc(y[7:0])};
  endfunction

  function automatic logic [15:0] year_dec(input logic [15:0] y);
    if (y == 16'h0000)        return 16'h9999;
    else if (y[7:0] == 8'h00) return {bcd_dec(y[15:8]), 8'h99};
    else                      return {y[15:8], bcd_dec(y[7:0])};
  endfunction

  function automatic logic div4(input logic [7:0] v);
    logic [6:0] b;
    b = {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
    return b[1:0] == 2'b00;
  endfunction

  // Century years are leap only when the century pair is itself divisible by 4.
  function automatic logic [7:0] days_in_month(input logic [7:0] m, input logic [15:0] y);
    logic leap;
    leap = (y[7:0] != 8'h00) ? div4(y[7:0]) : div4(y[15:8]);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return BLANK;
    endcase
  endfunction

  // Bit order: [3] sw_mode, [2] change, [1] decrease, [0] increase.
  logic [3:0] sync1, sync2, prev;
  logic [2:0] press;
  logic       sw_s, do_inc, do_dec, press_chg;

  logic [2:0]        state, state_n;
  logic [TICK_W-1:0] cnt;
  logic [7:0]        hour, minute, second, day, month;
  logic [15:0]       year;
  logic [7:0]        hour_n, minute_n, second_n, day_n, month_n;
  logic [15:0]       year_n;
  logic [7:0]        dim_cur, dim_new;

  logic [7:0][3:0] dig;
  logic [7:0]      blank_mask;
  logic [7:0][6:0] seg_n, seg_q;
  logic            time_page, blink_on;

  assign press     = prev[2:0] & ~sync2[2:0];
  assign sw_s      = sync2[3];
  assign press_chg = press[2];
  // Change wins over inc/dec; simultaneous inc and dec cancel.
  assign do_inc    = press[0] & ~press[1] & ~press_chg;
  assign do_dec    = press[1] & ~press[0] & ~press_chg;
  assign tick_1s   = (cnt == TICK_LAST);
  assign dim_cur   = days_in_month(month, year);
  assign dim_new   = days_in_month(month_n, year_n);

  always_comb begin
    state_n = state;
    if (press_chg) state_n = (state == ST_YEAR) ? ST_RUN : state + 3'd1;
  end

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    hour_n   = hour;
    minute_n = minute;
    second_n = second;
    day_n    = day;
    month_n  = month;
    year_n   = year;
    if (state == ST_RUN) begin
      if (tick_1s) begin
        if (second == 8'h59) begin
          second_n = 8'h00;
          if (minute == 8'h59) begin
            minute_n = 8'h00;
            if (hour == 8'h23) begin
              hour_n = 8'h00;
              if (day == dim_cur) begin
                day_n = 8'h01;
                if (month == 8'h12) begin
                  month_n = 8'h01;
                  year_n  = year_inc(year);
                end else begin
                  month_n = bcd_inc(month);
                end
              end else begin
                day_n = bcd_inc(day);
              end
            end else begin
              hour_n = bcd_inc(hour);
            end
          end else begin
            minute_n = bcd_inc(minute);
          end
        end else begin
          second_n = bcd_inc(second);
        end
      end
    end else if (do_inc || do_dec) begin
      case (state)
        ST_HOUR:  hour_n   = do_inc ? ((hour == 8'h23) ? 8'h00 : bcd_inc(hour))
                                    : ((hour == 8'h00) ? 8'h23 : bcd_dec(hour));
        ST_MIN:   minute_n = do_inc ? ((minute == 8'h59) ? 8'h00 : bcd_inc(minute))
                                    : ((minute == 8'h00) ? 8'h59 : bcd_dec(minute));
        ST_SEC:   second_n = do_inc ? ((second == 8'h59) ? 8'h00 : bcd_inc(second))
                                    : ((second == 8'h00) ? 8'h59 : bcd_dec(second));
        ST_DAY:   day_n    = do_inc ? ((day == dim_cur) ? 8'h01 : bcd_inc(day))
                                    : ((day == 8'h01) ? dim_cur : bcd_dec(day));
        ST_MONTH: month_n  = do_inc ? ((month == 8'h12) ? 8'h01 : bcd_inc(month))
                                    : ((month == 8'h01) ? 8'h12 : bcd_dec(month));
        ST_YEAR:  year_n   = do_inc ? year_inc(year) : year_dec(year);
        default: ;
      endcase
      if ((state == ST_MONTH || state == ST_YEAR) && day > dim_new) day_n = dim_new;
    end
  end

  always_comb begin
    time_page = (state == ST_RUN) ? ~sw_s : (state == ST_HOUR || state == ST_MIN || state == ST_SEC);
    blink_on  = (state != ST_RUN) && (cnt < TICK_HALF);
    if (time_page) begin
      dig = {hour, minute, second, 8'hFF};
    end else begin
      dig = {day, month, year};
    end
    case (state)
      ST_HOUR, ST_DAY:  blank_mask = 8'b1100_0000;
      ST_MIN, ST_MONTH: blank_mask = 8'b0011_0000;
      ST_SEC:           blank_mask = 8'b0000_1100;
      ST_YEAR:          blank_mask = 8'b0000_1111;
      default:          blank_mask = 8'b0000_0000;
    endcase
    for (int i = 0; i < 8; i++) begin
      seg_n[i] = (blank_mask[i] && blink_on) ? BLANK : seg_dec(dig[i]);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      sync1   <= '1;
      sync2   <= '1;
      prev    <= '1;
      state   <= ST_RUN;
      setting <= 1'b0;
      cnt     <= '0;
      hour    <= 8'h00;
      minute  <= 8'h00;
      second  <= 8'h00;
      day     <= 8'h01;
      month   <= 8'h01;
      year    <= RESET_YEAR_BCD;
      seg_q   <= {8{BLANK}};
    end else begin
      sync1   <= {sw_mode, butt_change, butt_decrease, butt_increase};
      sync2   <= sync1;
      prev    <= sync2;
      state   <= state_n;
      setting <= (state_n != ST_RUN);
      if ((state == ST_YEAR && press_chg) || tick_1s) cnt <= '0;
      else                                            cnt <= cnt + TICK_ONE;
      hour    <= hour_n;
      minute  <= minute_n;
      second  <= second_n;
      day     <= day_n;
      month   <= month_n;
      year    <= year_n;
      seg_q   <= seg_n;
    end
  end

  assign seg7 = seg_q[7];
  assign seg6 = seg_q[6];
  assign seg5 = seg_q[5];
  assign seg4 = seg_q[4];
  assign seg3 = seg_q[3];
  assign seg2 = seg_q[2];
  assign seg1 = seg_q[1];
  assign seg0 = seg_q[0];

endmodule

// File: tb/tb_clock_calendar_set.sv
// Directed bench for clock_calendar_set with an 8-cycle tick: ticking,
// full rollover, leap rules, set-mode clamp, key rules, blink and reset.
`timescale 1ns/1ps
module tb_clock_calendar_set;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_mode = 1'b0;
  logic butt_increase = 1'b1;
  logic butt_decrease = 1'b1;
  logic butt_change = 1'b1;
  logic [6:0] seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0;
  logic tick_1s, setting;
  logic [55:0] segs;

  int errors = 0;
  int checks = 0;
  int cur_year = 2024;

  clock_calendar_set #(.TICK_DIV(8), .TICK_W(4), .RESET_YEAR(2024)) dut (
    .clk(clk), .rst_n(rst_n), .sw_mode(sw_mode),
    .butt_increase(butt_increase), .butt_decrease(butt_decrease), .butt_change(butt_change),
    .seg7(seg7), .seg6(seg6), .seg5(seg5), .seg4(seg4),
    .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0),
    .tick_1s(tick_1s), .setting(setting)
  );

  assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [55:0] exp_time(input int h, input int m, input int s);
    return {seg_of(h / 10), seg_of(h % 10), seg_of(m / 10), seg_of(m % 10),
            seg_of(s / 10), seg_of(s % 10), 7'h7F, 7'h7F};
  endfunction

  function automatic logic [55:0] exp_date(input int d, input int mo, input int y);
    return {seg_of(d / 10), seg_of(d % 10), seg_of(mo / 10), seg_of(mo % 10),
            seg_of(y / 1000), seg_of((y / 100) % 10), seg_of((y / 10) % 10), seg_of(y % 10)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cur_year = 2024;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic i, input logic d, input logic c);
    butt_increase = ~i;
    butt_decrease = ~d;
    butt_change   = ~c;
    repeat (4) @(negedge clk);
    butt_increase = 1'b1;
    butt_decrease = 1'b1;
    butt_change   = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic presses(input logic up, input int n);
    repeat (n) press(up, ~up, 1'b0);
  endtask

  task automatic changes(input int n);
    repeat (n) press(1'b0, 1'b0, 1'b1);
  endtask

  task automatic goto_year(input int target);
    int up, dn;
    up = (target - cur_year + 10000) % 10000;
    dn = (cur_year - target + 10000) % 10000;
    if (up <= dn) presses(1'b1, up);
    else          presses(1'b0, dn);
    cur_year = target;
  endtask

  // Waits for the next tick, then two edges so the new count is on the segments.
  task automatic wait_tick_show(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick_1s && n < 32);
    checks++;
    if (tick_1s !== 1'b1) begin
      errors++;
      $display("FAIL %s: no tick_1s within %0d cycles", name, n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (segs !== {8{7'h7F}}) begin errors++; $display("FAIL reset_segs: got %h expected %h", segs, {8{7'h7F}}); end
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL reset_setting: got %b expected 0", setting); end
    checks++;
    if (tick_1s !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick_1s); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (segs !== exp_time(0, 0, 0)) begin errors++; $display("FAIL reset_time: got %h expected %h", segs, exp_time(0, 0, 0)); end
  endtask

  task automatic test_tick();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_1s && n < 32);
    checks++;
    if (tick_1s !== 1'b1) begin errors++; $display("FAIL first_tick: none within %0d cycles", n); end
    @(negedge clk);
    checks++;
    if (tick_1s !== 1'b0) begin errors++; $display("FAIL tick_width: got %b expected 0", tick_1s); end
    n = 1;
    do begin @(negedge clk); n++; end while (!tick_1s && n < 32);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL tick_period: got %0d expected 8", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (!tick_1s && n < 32);
    checks++;
    if (n !== 8) begin errors++; $display("FAIL tick_period2: got %0d expected 8", n); end
    repeat (2) @(negedge clk);
    checks++;
    if (segs !== exp_time(0, 0, 3)) begin errors++; $display("FAIL three_ticks: got %h expected %h", segs, exp_time(0, 0, 3)); end
  endtask

  task automatic test_rollover();
    sw_mode = 1'b0;
    do_reset();
    changes(1);
    checks++;
    if (setting !== 1'b1) begin errors++; $display("FAIL setting_enter: got %b expected 1", setting); end
    presses(1'b0, 1);  // hour 23
    changes(1);
    presses(1'b0, 1);  // min 59
    changes(1);
    presses(1'b0, 1);  // sec 59
    changes(1);
    presses(1'b0, 1);  // day 31
    changes(1);
    presses(1'b0, 1);  // month 12
    changes(1);
    goto_year(9999);
    changes(1);
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL setting_exit: got %b expected 0", setting); end
    checks++;
    if (segs !== exp_time(23, 59, 59)) begin errors++; $display("FAIL set_time: got %h expected %h", segs, exp_time(23, 59, 59)); end
    wait_tick_show("rollover_tick");
    checks++;
    if (segs !== exp_time(0, 0, 0)) begin errors++; $display("FAIL rollover_time: got %h expected %h", segs, exp_time(0, 0, 0)); end
    sw_mode = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (segs !== exp_date(1, 1, 0)) begin errors++; $display("FAIL rollover_date: got %h expected %h", segs, exp_date(1, 1, 0)); end
  endtask

  task automatic test_leap(input int y, input int exp_d, input int exp_mo);
    sw_mode = 1'b1;
    do_reset();
    changes(1);
    presses(1'b0, 1);
    changes(1);
    presses(1'b0, 1);
    changes(1);
    presses(1'b0, 1);
    changes(1);
    presses(1'b1, 27);  // day 28
    changes(1);
    presses(1'b1, 1);   // month 02
    changes(1);
    goto_year(y);
    changes(1);
    checks++;
    if (segs !== exp_date(28, 2, y)) begin errors++; $display("FAIL leap_pre_%0d: got %h expected %h", y, segs, exp_date(28, 2, y)); end
    wait_tick_show("leap_tick");
    checks++;
    if (segs !== exp_date(exp_d, exp_mo, y)) begin errors++; $display("FAIL leap_%0d: got %h expected %h", y, segs, exp_date(exp_d, exp_mo, y)); end
  endtask

  task automatic test_clamp();
    sw_mode = 1'b1;
    do_reset();
    changes(4);
    presses(1'b0, 1);   // day 31
    changes(2);
    goto_year(2023);
    changes(1);
    checks++;
    if (segs !== exp_date(31, 1, 2023)) begin errors++; $display("FAIL clamp_start: got %h expected %h", segs, exp_date(31, 1, 2023)); end
    changes(5);
    presses(1'b1, 1);
    changes(2);
    checks++;
    if (segs !== exp_date(28, 2, 2023)) begin errors++; $display("FAIL clamp_inc: got %h expected %h", segs, exp_date(28, 2, 2023)); end
    changes(5);
    presses(1'b0, 1);
    changes(2);
    checks++;
    if (segs !== exp_date(28, 1, 2023)) begin errors++; $display("FAIL clamp_dec: got %h expected %h", segs, exp_date(28, 1, 2023)); end
  endtask

  task automatic test_keys();
    sw_mode = 1'b0;
    do_reset();
    changes(1);
    butt_increase = 1'b0;
    repeat (100) @(negedge clk);
    butt_increase = 1'b1;
    repeat (4) @(negedge clk);
    changes(1);
    press(1'b1, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    checks++;
    if (setting !== 1'b1) begin errors++; $display("FAIL change_inc_setting: got %b expected 1", setting); end
    presses(1'b1, 1);
    changes(4);
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL keys_exit: got %b expected 0", setting); end
    checks++;
    if (segs !== exp_time(1, 0, 1)) begin errors++; $display("FAIL key_rules: got %h expected %h", segs, exp_time(1, 0, 1)); end
  endtask

  task automatic test_blink_reset();
    int blanks, shown, min_ok;
    sw_mode = 1'b0;
    do_reset();
    changes(1);
    presses(1'b1, 1);   // hour 01
    blanks = 0;
    shown = 0;
    min_ok = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (seg7 === 7'h7F && seg6 === 7'h7F) blanks++;
      if (seg7 === 7'h40 && seg6 === 7'h79) shown++;
      if (seg5 === 7'h40 && seg4 === 7'h40) min_ok++;
    end
    checks++;
    if (blanks !== 4) begin errors++; $display("FAIL blink_blank: got %0d expected 4", blanks); end
    checks++;
    if (shown !== 4) begin errors++; $display("FAIL blink_shown: got %0d expected 4", shown); end
    checks++;
    if (min_ok !== 8) begin errors++; $display("FAIL blink_other: got %0d expected 8", min_ok); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (setting !== 1'b0) begin errors++; $display("FAIL midset_reset_setting: got %b expected 0", setting); end
    checks++;
    if (segs !== {8{7'h7F}}) begin errors++; $display("FAIL midset_reset_segs: got %h expected %h", segs, {8{7'h7F}}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (segs !== exp_time(0, 0, 0)) begin errors++; $display("FAIL midset_reset_time: got %h expected %h", segs, exp_time(0, 0, 0)); end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_rollover();
    test_leap(2024, 29, 2);
    test_leap(2023, 1, 3);
    test_leap(1900, 1, 3);
    test_leap(2000, 29, 2);
    test_clamp();
    test_keys();
    test_blink_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
